// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB round-robin master.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    ERRDONE = 2'd3
  } state_t;

  localparam logic [31:0] ERR_RDATA   = 32'hDEADBEEF;
  localparam int          SLV_SEL_MSB = 15;
  localparam int          SLV_SEL_LSB = 12;

  // True when the address window field names an existing slave.
  function automatic logic slv_in_range(input logic [31:0] addr, input int num_slv);
    logic [31:0] win;
    win = {28'd0, addr[SLV_SEL_MSB:SLV_SEL_LSB]};
    return (win < $unsigned(num_slv));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after (ptr+1) mod N.
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  logic [W-1:0] idx_s;

  // Scan offsets 1..N; the first hit wins because gnt_valid blocks later ones.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx_s     = '0;
    for (int i = 1; i <= N; i++) begin
      idx_s     = W'((int'(ptr) + i) % N);
      gnt_idx   = (req[idx_s] && !gnt_valid) ? idx_s : gnt_idx;
      gnt_valid = gnt_valid | req[idx_s];
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master sequencer: arbitrates NUM_REQ requesters round-robin onto one
// APB bus, decodes the slave window and returns status to the owner.
module apb_rr_master #(
  parameter int NUM_REQ = 2,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    done,
  output logic [31:0]           rdata,
  output logic                  err,
  output logic [31:0]           PADDR,
  output logic [31:0]           PWDATA,
  output logic                  PWRITE,
  output logic [NUM_SLV-1:0]    PSEL,
  output logic                  PENABLE,
  input  logic [NUM_SLV*32-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]    PREADY,
  input  logic [NUM_SLV-1:0]    PSLVERR
);
  import apb_master_pkg::*;

  localparam int GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SLV_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [GNT_W-1:0] PTR_RST  = GNT_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [GNT_W-1:0]   ptr_q, ptr_d;
  logic [GNT_W-1:0]   gnt_q, gnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               write_q, write_d;
  logic [SLV_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [GNT_W-1:0]   gnt_idx_s;
  logic               gnt_valid_s;
  logic [31:0]        cand_addr_s;
  logic [NUM_REQ-1:0] owner_s;
  logic [31:0]        sel_rdata_s;

  rr_arbiter #(.N(NUM_REQ), .W(GNT_W)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_idx   (gnt_idx_s),
    .gnt_valid (gnt_valid_s)
  );

  assign cand_addr_s = req_addr[{gnt_idx_s, 5'd0} +: 32];
  assign owner_s     = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
  assign sel_rdata_s = PRDATA[{sel_q, 5'd0} +: 32];

  // Address/data/direction hold their last latched values once the bus idles.
  assign PADDR  = addr_q;
  assign PWDATA = wdata_q;
  assign PWRITE = write_q;

  // Bus control follows the phase; only SETUP and ACCESS select a slave.
  always_comb begin
    PSEL    = '0;
    PENABLE = 1'b0;
    case (state_q)
      SETUP:   PSEL = {{(NUM_SLV-1){1'b0}}, 1'b1} << sel_q;
      ACCESS: begin
        PSEL    = {{(NUM_SLV-1){1'b0}}, 1'b1} << sel_q;
        PENABLE = 1'b1;
      end
      default: PSEL = '0;
    endcase
  end

  // Next-state, latching and completion outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    done    = '0;
    rdata   = 32'd0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid_s) begin
          gnt_d   = gnt_idx_s;
          ptr_d   = gnt_idx_s;
          addr_d  = cand_addr_s;
          wdata_d = req_wdata[{gnt_idx_s, 5'd0} +: 32];
          write_d = req_write[gnt_idx_s];
          sel_d   = cand_addr_s[SLV_SEL_LSB +: SLV_W];
          if (slv_in_range(cand_addr_s, NUM_SLV)) begin
            state_d = SETUP;
          end else begin
            state_d = ERRDONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // Saturating so a long stall can never alias back to an early count.
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
        if (PREADY[sel_q]) begin
          done    = owner_s;
          err     = PSLVERR[sel_q];
          rdata   = write_q ? 32'd0 : sel_rdata_s;
          state_d = IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          done    = owner_s;
          err     = 1'b1;
          rdata   = ERR_RDATA;
          state_d = IDLE;
        end else begin
          state_d = ACCESS;
        end
      end
      ERRDONE: begin
        done    = owner_s;
        err     = 1'b1;
        rdata   = ERR_RDATA;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transfer-context registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      gnt_q   <= '0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed, table-driven bench for apb_rr_master with a small per-slave model.
module tb_apb_rr_master;

  localparam int NR = 2;
  localparam int NS = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [NR-1:0]     req;
  logic [NR*32-1:0]  req_addr;
  logic [NR-1:0]     req_write;
  logic [NR*32-1:0]  req_wdata;
  logic [NR-1:0]     done;
  logic [31:0]       rdata;
  logic              err;
  logic [31:0]       PADDR;
  logic [31:0]       PWDATA;
  logic              PWRITE;
  logic [NS-1:0]     PSEL;
  logic              PENABLE;
  logic [NS*32-1:0]  PRDATA;
  logic [NS-1:0]     PREADY;
  logic [NS-1:0]     PSLVERR;

  int checks   = 0;
  int failures = 0;

  apb_rr_master #(.NUM_REQ(NR), .NUM_SLV(NS), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rid;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        slverr;
    logic [3:0]  psel;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Target slave returns prd/slverr and the given ready; others answer with decoys.
  task automatic drive_slaves(input logic [31:0] addr, input logic [31:0] prd,
                              input logic slverr, input logic tgt_ready);
    logic [31:0] win;
    win = {28'd0, addr[15:12]};
    for (int s = 0; s < NS; s++) begin
      if (win == 32'(s)) begin
        PRDATA[s*32 +: 32] = prd;
        PREADY[s]          = tgt_ready;
        PSLVERR[s]         = slverr;
      end else begin
        PRDATA[s*32 +: 32] = 32'hBAD00000 | 32'(s);
        PREADY[s]          = 1'b1;
        PSLVERR[s]         = ~slverr;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    logic       got;
    int         lat;
    logic       psel_ok;
    logic       pen_ok;
    logic       bus_ok;
    logic [1:0] exp_done;
    exp_done = 2'b01 << v.rid;
    @(negedge clk);
    drive_slaves(v.addr, v.prdata, v.slverr, 1'b0);
    req_addr[v.rid*32 +: 32]  = v.addr;
    req_wdata[v.rid*32 +: 32] = v.wdata;
    req_write[v.rid]          = v.wr;
    req                       = exp_done;
    got = 1'b0; lat = 0; psel_ok = 1'b1; pen_ok = 1'b1; bus_ok = 1'b1;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      drive_slaves(v.addr, v.prdata, v.slverr, (n - 2) >= v.waits);
      #1;
      if (PSEL !== v.psel) psel_ok = 1'b0;
      if (PENABLE !== ((v.psel != 4'd0) && (n >= 2))) pen_ok = 1'b0;
      if ((v.psel != 4'd0) && (PADDR !== v.addr || PWDATA !== v.wdata || PWRITE !== v.wr))
        bus_ok = 1'b0;
      if (done !== 2'b00) begin
        got = 1'b1;
        lat = n;
        chk($sformatf("v%0d_done", k), 32'(done), 32'(exp_done));
        chk($sformatf("v%0d_rdata", k), rdata, v.exp_rdata);
        chk($sformatf("v%0d_err", k), 32'(err), 32'(v.exp_err));
        req = 2'b00;
      end
    end
    req = 2'b00;
    chk($sformatf("v%0d_latency", k), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_psel_stable", k), 32'(psel_ok), 32'd1);
    chk($sformatf("v%0d_penable", k), 32'(pen_ok), 32'd1);
    chk($sformatf("v%0d_bus_stable", k), 32'(bus_ok), 32'd1);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_idle_psel", k), 32'(PSEL), 32'd0);
    chk($sformatf("v%0d_idle_penable", k), 32'(PENABLE), 32'd0);
    chk($sformatf("v%0d_idle_done", k), 32'(done), 32'd0);
    chk($sformatf("v%0d_idle_paddr_hold", k), PADDR, v.addr);
  endtask

  initial begin
    logic [1:0] exp_d;
    logic [3:0] exp_ps;
    logic       exp_pe;

    //        rid wr    addr           wdata          prdata         waits slverr psel    lat rdata          err
    vt[0] = '{0, 1'b0, 32'h0000_1008, 32'h0000_0000, 32'h0000_005A, 0,  1'b0, 4'b0010, 2,  32'h0000_005A, 1'b0};
    vt[1] = '{0, 1'b1, 32'h0000_0004, 32'h0000_1234, 32'h1111_2222, 3,  1'b0, 4'b0001, 5,  32'h0000_0000, 1'b0};
    vt[2] = '{0, 1'b0, 32'h0000_7000, 32'h0000_0000, 32'h0000_0000, 0,  1'b0, 4'b0000, 1,  32'hDEADBEEF, 1'b1};
    vt[3] = '{0, 1'b0, 32'h0000_3010, 32'h0000_0000, 32'h0000_00AA, 99, 1'b0, 4'b1000, 17, 32'hDEADBEEF, 1'b1};
    vt[4] = '{1, 1'b0, 32'h0000_2020, 32'h0000_0000, 32'h0000_CAFE, 0,  1'b1, 4'b0100, 2,  32'h0000_CAFE, 1'b1};
    vt[5] = '{0, 1'b1, 32'h0000_3000, 32'hA5A5_0001, 32'h3333_4444, 1,  1'b1, 4'b1000, 3,  32'h0000_0000, 1'b1};
    vt[6] = '{1, 1'b0, 32'h0000_4000, 32'h0000_0000, 32'h0000_0000, 0,  1'b0, 4'b0000, 1,  32'hDEADBEEF, 1'b1};

    n_rst     = 1'b0;
    req       = 2'b00;
    req_addr  = '0;
    req_write = 2'b00;
    req_wdata = '0;
    drive_slaves(32'h0000_1000, 32'h0000_0055, 1'b0, 1'b1);
    #12;
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(vt[k], k);

    // Both requesters hold req; the last vector left requester 1 as owner,
    // so requester 0 is served first and grants alternate every 3 cycles.
    @(negedge clk);
    drive_slaves(32'h0000_1000, 32'h0000_0077, 1'b0, 1'b1);
    req_addr  = {32'h0000_1000, 32'h0000_1000};
    req_write = 2'b00;
    req       = 2'b11;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      #1;
      exp_d  = (n % 3 == 2) ? (((n / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_ps = (n % 3 == 0) ? 4'b0000 : 4'b0010;
      exp_pe = (n % 3 == 2);
      chk($sformatf("rr_done_c%0d", n), 32'(done), 32'(exp_d));
      chk($sformatf("rr_psel_c%0d", n), 32'(PSEL), 32'(exp_ps));
      chk($sformatf("rr_penable_c%0d", n), 32'(PENABLE), 32'(exp_pe));
      if (exp_d != 2'b00) chk($sformatf("rr_rdata_c%0d", n), rdata, 32'h0000_0077);
      if (n == 11) req = 2'b00;
    end

    // Reset asserted mid-ACCESS with the slave stalling.
    @(negedge clk);
    drive_slaves(32'h0000_2000, 32'h0000_0000, 1'b0, 1'b0);
    req_addr[31:0] = 32'h0000_2000;
    req            = 2'b01;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst_mid_in_access", 32'(PENABLE), 32'd1);
    n_rst = 1'b0;
    #1;
    chk("rst_mid_psel", 32'(PSEL), 32'd0);
    chk("rst_mid_penable", 32'(PENABLE), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_paddr", PADDR, 32'd0);
    req_addr = {32'h0000_1000, 32'h0000_1000};
    req      = 2'b11;
    drive_slaves(32'h0000_1000, 32'h0000_0099, 1'b0, 1'b1);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_setup_psel", 32'(PSEL), 32'(4'b0010));
    @(negedge clk);
    #1;
    chk("post_rst_first_owner", 32'(done), 32'(2'b01));
    chk("post_rst_rdata", rdata, 32'h0000_0099);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
